// File: rtl/tia_object_position_counter_p.sv
// Horizontal position counter for one movable object (missile/ball class).
// Keeps a modulo-PERIOD pixel counter, decodes copy start points and draws
// a 1/2/4/8 pixel wide object START_DELAY count steps after each start.
module tia_object_position_counter_p #(
    parameter int unsigned PERIOD      = 160,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned START_DELAY = 4,
    parameter int unsigned LOCK_LOAD   = 0
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             pix_en,
    input  logic             hmove_pulse,
    input  logic             obj_reset,
    input  logic             lock_reset,
    input  logic             enable,
    input  logic [1:0]       size,
    input  logic [2:0]       copies,
    output logic             out,
    output logic [CNT_W-1:0] pos,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LAST     = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_LOAD);
    localparam logic [2:0]       DLY      = 3'(START_DELAY);

    // The farthest copy (64) plus its delay and widest draw must finish
    // before the line wraps, otherwise copies would overlap the next start.
    if (PERIOD <= 64 + START_DELAY + 8) begin : g_period_chk
        $error("PERIOD too short for copy offsets plus start delay and width");
    end
    if (START_DELAY < 1 || START_DELAY > 7) begin : g_delay_chk
        $error("START_DELAY must be within 1..7");
    end
    if ((64'd1 << CNT_W) < 64'(PERIOD)) begin : g_width_chk
        $error("CNT_W too narrow for PERIOD");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dly_q, dly_d;
    logic [3:0]       draw_q, draw_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;

    logic             cnt_en;
    logic             cnt_wrap;
    logic [CNT_W-1:0] cnt_inc;
    logic             hit16, hit32, hit64;
    logic             start;
    logic             overlap;

    // Count step, wrap detection and copy start decode
    always_comb begin
        cnt_en   = pix_en | hmove_pulse;
        cnt_wrap = (cnt_q == LAST);
        cnt_inc  = cnt_wrap ? '0 : cnt_q + CNT_W'(1);
        hit16    = (copies == 3'b001) || (copies == 3'b011);
        hit32    = (copies == 3'b010) || (copies == 3'b011) || (copies == 3'b110);
        hit64    = (copies == 3'b100) || (copies == 3'b110);
        // Offset 0 only starts on a wrap; a strobe or lock load of 0 is not a step.
        start    = cnt_wrap
                || (hit16 && (cnt_inc == CNT_W'(16)))
                || (hit32 && (cnt_inc == CNT_W'(32)))
                || (hit64 && (cnt_inc == CNT_W'(64)));
    end

    // Next-state: lock > strobe > count step; delay then draw sequencing
    always_comb begin
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        draw_d  = draw_q;
        overlap = 1'b0;
        if (lock_reset) begin
            cnt_d  = LOCK_VAL;
            dly_d  = '0;
            draw_d = '0;
        end else if (obj_reset) begin
            cnt_d  = '0;
            dly_d  = '0;
            draw_d = '0;
        end else if (cnt_en) begin
            cnt_d = cnt_inc;
            if (start) begin
                overlap = busy_q;
                dly_d   = DLY;
                draw_d  = '0;
            end else if (dly_q != '0) begin
                dly_d = dly_q - 3'd1;
                // Width is captured here; later size changes do not affect this copy.
                if (dly_q == 3'd1) begin
                    draw_d = 4'd1 << size;
                end
            end else if (draw_q != '0) begin
                draw_d = draw_q - 4'd1;
            end
        end
        out_d  = enable & (draw_d != '0);
        busy_d = (dly_d != '0) | (draw_d != '0);
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            cnt_q  <= '0;
            dly_q  <= '0;
            draw_q <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dly_q  <= dly_d;
            draw_q <= draw_d;
            out_q  <= out_d;
            busy_q <= busy_d;
            // Copy spacing exceeds delay plus widest draw, so a start never lands mid-object.
            assert (!overlap);
        end
    end

    assign out  = out_q;
    assign pos  = cnt_q;
    assign busy = busy_q;

endmodule

// File: doc/tia_object_position_counter_p.md
Name: tia_object_position_counter_p

Overview:
- Parametrised, single-clock successor to the per-object horizontal position counters (missile/ball class).
- Holds a modulo-PERIOD horizontal counter, decodes copy start points from a copy-mode field and draws a configurable-width object after a fixed start delay.
- Supports HMOVE-style extra count pulses and a lock-to-parent mode (missile-to-player reset).
- Sits between the register-strobe decode and the playfield/collision mux; one instance per movable object.

Parameters:
- PERIOD, 160, count steps per scan line; counter wraps PERIOD-1 -> 0.
- CNT_W, 8, counter width; must satisfy 2^CNT_W >= PERIOD.
- START_DELAY, 4, count steps from start decode to first drawn pixel; legal range 1..7.
- LOCK_LOAD, 0, counter value held while lock_reset is high.

Ports:
- clk  input  1  pixel-rate clock.
- reset_bar  input  1  asynchronous, active-low reset.
- pix_en  input  1  normal count enable (one per visible/blank pixel clock).
- hmove_pulse  input  1  extra count request from motion logic.
- obj_reset  input  1  position strobe (RESMx/RESBL); one-cycle pulse.
- lock_reset  input  1  level; hold at LOCK_LOAD and blank output.
- enable  input  1  graphics enable (ENAMx); gates output only.
- size  input  2  width select; drawn width = 1<<size pixels (1, 2, 4, 8).
- copies  input  3  copy-offset mode.
- out  output  1  object pixel, registered.
- pos  output  CNT_W  current counter value.
- busy  output  1  delay or draw in progress.

Behaviour:
- Reset (reset_bar low, asynchronous):
  - out=0, pos=0, busy=0; delay and draw counters cleared.
  - Release is synchronous to the next clk edge.
- Count step:
  - cnt_en = pix_en | hmove_pulse.
  - Both inputs high in the same cycle = one step, not two.
  - Counter advances by 1 per step, wraps PERIOD-1 -> 0.
- Priority, per edge: lock_reset > obj_reset > count step.
- lock_reset high:
  - pos forced to LOCK_LOAD; delay and draw cancelled; out=0.
  - After release, counting resumes from LOCK_LOAD.
  - No start is generated at LOCK_LOAD itself.
- obj_reset high:
  - pos loads 0; pending delay and active draw are cancelled; out drops on that edge.
  - Loading 0 is NOT a start; the primary copy first appears after the next wrap.
- Copy offsets by copies:
  - 000 {0}
  - 001 {0,16}
  - 010 {0,32}
  - 011 {0,16,32}
  - 100 {0,64}
  - 101 {0}
  - 110 {0,32,64}
  - 111 {0}
- Start event:
  - Occurs on a count step whose resulting counter value is in the offset set.
  - Offset 0 counts only when reached by wrap.
  - Start loads the delay counter with START_DELAY; busy=1.
- Delay phase:
  - Each later count step decrements the delay counter.
  - The step that takes it to 0 loads the draw counter with 1<<size and sets out=1 on that edge (gated by enable).
- Draw phase:
  - Each count step decrements the draw counter.
  - out stays high for exactly 1<<size count steps, then clears; busy clears with it.
- Stall: with cnt_en low, every counter and out hold. Stretching count steps stretches the object.
- Mid-draw changes:
  - size is sampled at draw start; changes mid-draw are ignored.
  - enable is applied combinationally before the out register, so it takes effect at the next edge.
- New start during delay or draw: restart the delay phase. Unreachable with legal parameters; verify by assertion.
- Parameter guard: PERIOD > 64 + START_DELAY + 8 is an elaboration-time assertion.
- pos is a registered counter copy with zero latency relative to the internal counter.

Test Plan:
- Reset mid-draw: pix_en=1, size=3, assert reset_bar low mid-object -> out, pos and busy equal 0 immediately, with no clk edge needed.
- Basic line: pix_en=1, copies=000, size=0, enable=1, counter wraps to 0 at edge k -> out high only at edge k+4, once per 160 cycles.
- Copies and width: copies=110, size=2 -> three 4-pixel runs starting at k+4, k+36 and k+68; pos wraps at 159 -> 0.
- Reset strobe: pulse obj_reset at pos=50 while drawing -> out=0 next edge, pos=0, no object until the following wrap plus 4.
- Motion: pix_en=0 with 8 hmove_pulse cycles -> pos advances 8. pix_en and hmove_pulse both high for 10 cycles -> pos advances 10, not 20.
- Lock: hold lock_reset for 200 cycles -> pos=LOCK_LOAD and out=0 throughout; after release the first object appears START_DELAY steps after the next wrap. enable=0 suppresses out while pos and busy still sequence.
